// File: rtl/arcino_imem_arbiter.sv
// Two-master arbiter for a single req/gnt/rvalid instruction-memory port.
// M0 is the read-only prefetch port and M1 is the read/write debug/loader port.
module arcino_imem_arbiter #(
  parameter bit FAIR = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a request is transferred on a cycle where mem_req_o && mem_gnt_i;
  // exactly one rvalid follows later and is routed to the master that won that grant.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCKED  = 2'd1,
    WAIT_RV = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   rr_q, rr_d;
  logic   abandoned_q;

  logic any_req;
  logic both_req;
  logic arb_sel;
  logic free_slot;
  logic owner_req;
  logic issue_sel;
  logic issue;
  logic rv_fwd;

  assign any_req   = m0_req_i | m1_req_i;
  assign both_req  = m0_req_i & m1_req_i;
  assign free_slot = (state_q == IDLE) || ((state_q == WAIT_RV) && mem_rvalid_i);
  assign owner_req = owner_q ? m1_req_i : m0_req_i;

  always_comb begin
    arb_sel = m1_req_i;
    if (both_req) begin
      arb_sel = FAIR ? rr_q : 1'b1;
    end
  end

  // A stalled request stays pinned to its owner so a branch redirect can change the address.
  assign issue_sel = (state_q == LOCKED) ? owner_q : arb_sel;
  assign issue     = (state_q == LOCKED) ? owner_req : (free_slot & any_req);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE, WAIT_RV: begin
        if (free_slot) begin
          if (any_req) begin
            owner_d = arb_sel;
            if (mem_gnt_i) begin
              state_d = WAIT_RV;
              rr_d    = ~arb_sel;
            end else begin
              state_d = LOCKED;
            end
          end else begin
            state_d = IDLE;
          end
        end
      end
      LOCKED: begin
        if (!owner_req) begin
          state_d = IDLE;
        end else if (mem_gnt_i) begin
          state_d = WAIT_RV;
          rr_d    = ~owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rv_fwd = rst_ni && (state_q == WAIT_RV) && mem_rvalid_i;

  always_comb begin
    mem_req_o   = rst_ni & issue;
    mem_addr_o  = issue_sel ? m1_addr_i : m0_addr_i;
    mem_we_o    = issue_sel & m1_we_i;
    mem_be_o    = issue_sel ? m1_be_i : 4'hF;
    mem_wdata_o = issue_sel ? m1_wdata_i : 32'h0;
    m0_gnt_o    = mem_req_o & ~issue_sel & mem_gnt_i;
    m1_gnt_o    = mem_req_o & issue_sel & mem_gnt_i;
    m0_rvalid_o = rv_fwd & ~owner_q;
    m1_rvalid_o = rv_fwd & owner_q;
    m0_rdata_o  = mem_rdata_i;
    m1_rdata_o  = mem_rdata_i;
    busy_o      = rst_ni & (state_q != IDLE);
    dbg_state_o = state_q;
  end

  // Remembers a response orphaned by reset so its late rvalid is not reported as a protocol error.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      abandoned_q <= abandoned_q | (state_q == WAIT_RV);
    end else if ((mem_rvalid_i && (state_q != WAIT_RV)) || (mem_req_o && mem_gnt_i)) begin
      abandoned_q <= 1'b0;
    end
  end

  a_no_stray_rvalid: assert property (@(posedge clk_i)
    (rst_ni && mem_rvalid_i && (state_q != WAIT_RV)) |-> abandoned_q);

endmodule

// File: tb/tb_arcino_imem_arbiter.sv
// Bench for arcino_imem_arbiter: instance 0 is round-robin, instance 1 fixed priority.
// Directed scenarios plus a randomized run against a transaction-level model.
module tb_arcino_imem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic        m1_req;
  logic [31:0] m1_addr;
  logic        m1_we;
  logic [3:0]  m1_be;
  logic [31:0] m1_wdata;

  logic        mem_gnt    [2];
  logic        mem_rvalid [2];
  logic [31:0] mem_rdata  [2];

  logic        m0_gnt     [2];
  logic        m0_rvalid  [2];
  logic [31:0] m0_rdata   [2];
  logic        m1_gnt     [2];
  logic        m1_rvalid  [2];
  logic [31:0] m1_rdata   [2];
  logic        mem_req    [2];
  logic [31:0] mem_addr   [2];
  logic        mem_we     [2];
  logic [3:0]  mem_be     [2];
  logic [31:0] mem_wdata  [2];
  logic        busy       [2];
  logic [1:0]  dbg_state  [2];

  int tests_run;
  int tests_failed;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    arcino_imem_arbiter #(.FAIR((g == 0) ? 1'b1 : 1'b0)) u_dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .m0_req_i     (m0_req),
      .m0_addr_i    (m0_addr),
      .m0_gnt_o     (m0_gnt[g]),
      .m0_rvalid_o  (m0_rvalid[g]),
      .m0_rdata_o   (m0_rdata[g]),
      .m1_req_i     (m1_req),
      .m1_addr_i    (m1_addr),
      .m1_we_i      (m1_we),
      .m1_be_i      (m1_be),
      .m1_wdata_i   (m1_wdata),
      .m1_gnt_o     (m1_gnt[g]),
      .m1_rvalid_o  (m1_rvalid[g]),
      .m1_rdata_o   (m1_rdata[g]),
      .mem_req_o    (mem_req[g]),
      .mem_gnt_i    (mem_gnt[g]),
      .mem_addr_o   (mem_addr[g]),
      .mem_we_o     (mem_we[g]),
      .mem_be_o     (mem_be[g]),
      .mem_wdata_o  (mem_wdata[g]),
      .mem_rvalid_i (mem_rvalid[g]),
      .mem_rdata_i  (mem_rdata[g]),
      .busy_o       (busy[g]),
      .dbg_state_o  (dbg_state[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Control vector: {mem_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, busy}
  function automatic logic [5:0] ctl(input int i);
    return {mem_req[i], m0_gnt[i], m1_gnt[i], m0_rvalid[i], m1_rvalid[i], busy[i]};
  endfunction

  task automatic idle_inputs();
    m0_req   = 1'b0;
    m0_addr  = 32'h0;
    m1_req   = 1'b0;
    m1_addr  = 32'h0;
    m1_we    = 1'b0;
    m1_be    = 4'h0;
    m1_wdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      mem_gnt[i]    = 1'b0;
      mem_rvalid[i] = 1'b0;
      mem_rdata[i]  = 32'h0;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    idle_inputs();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n   = 1'b0;
    m0_req  = 1'b1;
    m1_req  = 1'b1;
    mem_gnt[0] = 1'b1;
    mem_gnt[1] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (ctl(i) !== 6'b000000) begin
        tests_failed++;
        $display("FAIL reset_forced inst%0d ctl got %b want %b", i, ctl(i), 6'b000000);
      end
    end
    next_cycle();
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if ({ctl(i), dbg_state[i]} !== 8'b000000_00) begin
        tests_failed++;
        $display("FAIL reset_idle inst%0d ctl/state got %b want %b", i, {ctl(i), dbg_state[i]}, 8'b0);
      end
    end
    next_cycle();
  endtask

  task automatic test_m0_read();
    logic [5:0] exp_ctl [4];
    exp_ctl[0] = 6'b110000;
    exp_ctl[1] = 6'b000001;
    exp_ctl[2] = 6'b000101;
    exp_ctl[3] = 6'b000000;
    reset_pulse();
    for (int c = 0; c < 4; c++) begin
      idle_inputs();
      if (c == 0) begin
        m0_req     = 1'b1;
        m0_addr    = 32'h100;
        mem_gnt[0] = 1'b1;
      end
      if (c == 2) begin
        mem_rvalid[0] = 1'b1;
        mem_rdata[0]  = 32'hDEADBEEF;
      end
      @(negedge clk);
      tests_run++;
      if (ctl(0) !== exp_ctl[c]) begin
        tests_failed++;
        $display("FAIL m0_read cycle%0d ctl got %b want %b", c, ctl(0), exp_ctl[c]);
      end
      if (c == 0) begin
        tests_run++;
        if ({mem_addr[0], mem_we[0], mem_be[0], mem_wdata[0]} !== {32'h100, 1'b0, 4'hF, 32'h0}) begin
          tests_failed++;
          $display("FAIL m0_read_bus got %h/%b/%h/%h want 100/0/f/0", mem_addr[0], mem_we[0], mem_be[0], mem_wdata[0]);
        end
      end
      if (c == 2) begin
        tests_run++;
        if ({m0_rdata[0], m1_rdata[0]} !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
          tests_failed++;
          $display("FAIL m0_read_rdata got %h/%h want deadbeef", m0_rdata[0], m1_rdata[0]);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_round_robin();
    logic [5:0] exp_ctl [6];
    exp_ctl[0] = 6'b110000;
    exp_ctl[1] = 6'b101101;
    exp_ctl[2] = 6'b110011;
    exp_ctl[3] = 6'b101101;
    exp_ctl[4] = 6'b000011;
    exp_ctl[5] = 6'b000000;
    reset_pulse();
    for (int c = 0; c < 6; c++) begin
      idle_inputs();
      if (c < 4) begin
        m0_req  = 1'b1;
        m0_addr = 32'h2000 + 32'(c * 4);
        m1_req  = 1'b1;
        m1_addr = 32'h8000 + 32'(c * 4);
      end
      mem_gnt[0]    = (c < 4);
      mem_rvalid[0] = (c >= 1) && (c <= 4);
      mem_rdata[0]  = 32'hA000 + 32'(c);
      @(negedge clk);
      tests_run++;
      if (ctl(0) !== exp_ctl[c]) begin
        tests_failed++;
        $display("FAIL round_robin cycle%0d ctl got %b want %b", c, ctl(0), exp_ctl[c]);
      end
      next_cycle();
    end
  endtask

  task automatic test_locked_switch();
    logic [5:0]  exp_ctl  [8];
    logic [31:0] exp_addr [8];
    exp_ctl[0] = 6'b100000; exp_addr[0] = 32'h100;
    exp_ctl[1] = 6'b100001; exp_addr[1] = 32'h200;
    exp_ctl[2] = 6'b100001; exp_addr[2] = 32'h200;
    exp_ctl[3] = 6'b110001; exp_addr[3] = 32'h200;
    exp_ctl[4] = 6'b000001; exp_addr[4] = 32'h0;
    exp_ctl[5] = 6'b101101; exp_addr[5] = 32'h300;
    exp_ctl[6] = 6'b000011; exp_addr[6] = 32'h0;
    exp_ctl[7] = 6'b000000; exp_addr[7] = 32'h0;
    reset_pulse();
    for (int c = 0; c < 8; c++) begin
      idle_inputs();
      m0_req        = (c < 4);
      m0_addr       = (c == 0) ? 32'h100 : 32'h200;
      m1_req        = (c < 6);
      m1_addr       = 32'h300;
      mem_gnt[0]    = (c >= 3);
      mem_rvalid[0] = (c == 5) || (c == 6);
      @(negedge clk);
      tests_run++;
      if (ctl(0) !== exp_ctl[c]) begin
        tests_failed++;
        $display("FAIL locked_switch cycle%0d ctl got %b want %b", c, ctl(0), exp_ctl[c]);
      end
      if (exp_ctl[c][5]) begin
        tests_run++;
        if (mem_addr[0] !== exp_addr[c]) begin
          tests_failed++;
          $display("FAIL locked_switch_addr cycle%0d got %h want %h", c, mem_addr[0], exp_addr[c]);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_fixed_priority();
    logic [5:0] exp_ctl [4];
    exp_ctl[0] = 6'b101000;
    exp_ctl[1] = 6'b110011;
    exp_ctl[2] = 6'b000101;
    exp_ctl[3] = 6'b000000;
    reset_pulse();
    for (int c = 0; c < 4; c++) begin
      idle_inputs();
      m0_req   = (c < 2);
      m0_addr  = 32'h400;
      m1_req   = (c == 0);
      m1_addr  = 32'h1000;
      m1_we    = 1'b1;
      m1_be    = 4'b0011;
      m1_wdata = 32'h12345678;
      mem_gnt[1]    = (c < 2);
      mem_rvalid[1] = (c == 1) || (c == 2);
      @(negedge clk);
      tests_run++;
      if (ctl(1) !== exp_ctl[c]) begin
        tests_failed++;
        $display("FAIL fixed_prio cycle%0d ctl got %b want %b", c, ctl(1), exp_ctl[c]);
      end
      if (c == 0) begin
        tests_run++;
        if ({mem_addr[1], mem_we[1], mem_be[1], mem_wdata[1]} !== {32'h1000, 1'b1, 4'b0011, 32'h12345678}) begin
          tests_failed++;
          $display("FAIL fixed_prio_m1_bus got %h/%b/%b/%h want 1000/1/0011/12345678", mem_addr[1], mem_we[1], mem_be[1], mem_wdata[1]);
        end
      end
      if (c == 1) begin
        tests_run++;
        if ({mem_addr[1], mem_we[1], mem_be[1], mem_wdata[1]} !== {32'h400, 1'b0, 4'hF, 32'h0}) begin
          tests_failed++;
          $display("FAIL fixed_prio_m0_bus got %h/%b/%b/%h want 400/0/1111/0", mem_addr[1], mem_we[1], mem_be[1], mem_wdata[1]);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_drop_locked();
    logic [5:0] exp_ctl [3];
    exp_ctl[0] = 6'b100000;
    exp_ctl[1] = 6'b000001;
    exp_ctl[2] = 6'b000000;
    reset_pulse();
    for (int c = 0; c < 3; c++) begin
      idle_inputs();
      m0_req  = (c == 0);
      m0_addr = 32'h600;
      @(negedge clk);
      tests_run++;
      if (ctl(0) !== exp_ctl[c]) begin
        tests_failed++;
        $display("FAIL drop_locked cycle%0d ctl got %b want %b", c, ctl(0), exp_ctl[c]);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_wait_rv();
    reset_pulse();
    for (int c = 0; c < 4; c++) begin
      idle_inputs();
      rst_n         = (c != 1);
      m0_req        = (c == 0);
      m0_addr       = 32'h700;
      mem_gnt[0]    = (c == 0);
      mem_rvalid[0] = (c == 2);
      mem_rdata[0]  = 32'hBAD0BAD0;
      @(negedge clk);
      tests_run++;
      if (ctl(0) !== ((c == 0) ? 6'b110000 : 6'b000000)) begin
        tests_failed++;
        $display("FAIL reset_wait_rv cycle%0d ctl got %b want %b", c, ctl(0), (c == 0) ? 6'b110000 : 6'b000000);
      end
      next_cycle();
    end
  endtask

  // Transaction-level model: outstanding response owner, pinned stalled request, preferred master.
  task automatic test_random();
    int  outst [2];
    int  owner [2];
    int  locked[2];
    int  pref  [2];
    int  issuer;
    logic e_req, e_g0, e_g1, e_rv0, e_rv1, e_busy;
    logic [5:0]  exp_ctl;
    logic [68:0] exp_bus;
    reset_pulse();
    for (int i = 0; i < 2; i++) begin
      outst[i] = 0; owner[i] = 0; locked[i] = 0; pref[i] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      rst_n    = ($urandom_range(0, 63) != 0);
      m0_req   = ($urandom_range(0, 2) != 0);
      m0_addr  = $urandom;
      m1_req   = ($urandom_range(0, 2) == 0);
      m1_addr  = $urandom;
      m1_we    = $urandom_range(0, 1);
      m1_be    = 4'($urandom_range(0, 15));
      m1_wdata = $urandom;
      for (int i = 0; i < 2; i++) begin
        mem_gnt[i]    = ($urandom_range(0, 2) != 0);
        mem_rvalid[i] = (outst[i] != 0) && ($urandom_range(0, 2) != 0);
        mem_rdata[i]  = $urandom;
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        issuer = 0;
        e_req  = 1'b0;
        if (locked[i] != 0) begin
          issuer = owner[i];
          e_req  = (owner[i] == 1) ? m1_req : m0_req;
        end else if (((outst[i] == 0) || mem_rvalid[i]) && (m0_req || m1_req)) begin
          e_req = 1'b1;
          if (m0_req && m1_req) issuer = (i == 0) ? pref[i] : 1;
          else issuer = m1_req ? 1 : 0;
        end
        e_g0   = e_req && (issuer == 0) && mem_gnt[i];
        e_g1   = e_req && (issuer == 1) && mem_gnt[i];
        e_rv0  = (outst[i] != 0) && mem_rvalid[i] && (owner[i] == 0);
        e_rv1  = (outst[i] != 0) && mem_rvalid[i] && (owner[i] == 1);
        e_busy = (locked[i] != 0) || (outst[i] != 0);
        exp_ctl = rst_n ? {e_req, e_g0, e_g1, e_rv0, e_rv1, e_busy} : 6'b000000;
        tests_run++;
        if (ctl(i) !== exp_ctl) begin
          tests_failed++;
          $display("FAIL random_ctl inst%0d cycle%0d got %b want %b", i, c, ctl(i), exp_ctl);
        end
        tests_run++;
        if ({m0_rdata[i], m1_rdata[i]} !== {mem_rdata[i], mem_rdata[i]}) begin
          tests_failed++;
          $display("FAIL random_rdata inst%0d cycle%0d got %h/%h want %h", i, c, m0_rdata[i], m1_rdata[i], mem_rdata[i]);
        end
        if (rst_n && e_req) begin
          exp_bus = (issuer == 1) ? {m1_addr, m1_we, m1_be, m1_wdata} : {m0_addr, 1'b0, 4'hF, 32'h0};
          tests_run++;
          if ({mem_addr[i], mem_we[i], mem_be[i], mem_wdata[i]} !== exp_bus) begin
            tests_failed++;
            $display("FAIL random_bus inst%0d cycle%0d got %h want %h", i, c, {mem_addr[i], mem_we[i], mem_be[i], mem_wdata[i]}, exp_bus);
          end
        end
        if (!rst_n) begin
          outst[i] = 0; owner[i] = 0; locked[i] = 0; pref[i] = 0;
        end else begin
          if ((outst[i] != 0) && mem_rvalid[i]) outst[i] = 0;
          if (e_req) begin
            owner[i] = issuer;
            if (mem_gnt[i]) begin
              outst[i]  = 1;
              locked[i] = 0;
              pref[i]   = 1 - issuer;
            end else begin
              locked[i] = 1;
            end
          end else begin
            locked[i] = 0;
          end
        end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    idle_inputs();
    rst_n = 1'b0;
    next_cycle();
    test_reset();
    test_m0_read();
    test_round_robin();
    test_locked_switch();
    test_fixed_priority();
    test_drop_locked();
    test_reset_wait_rv();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
